pile_bank: RTL and testbench

Parametrised bank of NPILES brick-pile height counters driven by three player buttons: add, remove and move. Successor to the single-pile up/down counter.
- Adds per-pile selection and an atomic move of one brick between two piles.
- Adds configurable saturation or wrap, input debouncing, a rejection flag and a total brick count.
- Sits between the button synchronisers and the display/game-logic blocks.

---
 rtl/pile_bank.sv | 139 +++++++++++++
 tb/tb_pile_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pile_bank.sv
// Bank of NPILES brick-pile height counters driven by debounced Plus/Moins/Move buttons.
// Keeps a registered running total and pulses error for one cycle on a rejected or clamped command.
module pile_bank #(
  parameter int NPILES   = 3,
  parameter int WIDTH    = 3,
  parameter int MAXH     = 7,
  parameter int SAT      = 1,
  parameter int DEBOUNCE = 0,
  parameter int INIT_H0  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Plus,
  input  logic                      Moins,
  input  logic                      Move,
  input  logic [2:0]                sel_src,
  input  logic [2:0]                sel_dst,
  output logic [NPILES*WIDTH-1:0]   Hauteurs,
  output logic [WIDTH+2:0]          total,
  output logic                      error
);

  localparam int              CW   = $clog2(DEBOUNCE + 2);
  localparam int              TW   = WIDTH + 3;
  localparam logic [WIDTH-1:0] HMAX = WIDTH'(MAXH);
  localparam logic [3:0]      NP4  = 4'(NPILES);

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] h);
    return (h == HMAX) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] h);
    return (h == '0) ? HMAX : h - 1'b1;
  endfunction

  logic [2:0]       v;
  logic [2:0]       f_p0;
  logic [2:0]       vlast_p0;
  logic [CW-1:0]    cnt_p0;
  logic [CW-1:0]    run;
  logic             armed_p0;
  logic             accept;
  logic             issue;
  logic [WIDTH-1:0] h_p0 [NPILES];
  logic [WIDTH-1:0] h_d  [NPILES];
  logic [WIDTH-1:0] src_h, dst_h, src_n, dst_n;
  logic             src_ok, dst_ok, wr_src, wr_dst, err_d;
  logic [TW-1:0]    tot_d;

  assign v = {Move, Moins, Plus};

  // armed_p0 stays low after reset until the buttons are seen released, so a press held through reset is dropped
  always_comb begin
    run    = (v == vlast_p0 && cnt_p0 != '0) ? cnt_p0 + 1'b1 : CW'(1);
    accept = (v != f_p0) && (run == CW'(DEBOUNCE + 1));
    issue  = accept && (f_p0 == 3'b000) && armed_p0 &&
             (v == 3'b001 || v == 3'b010 || v == 3'b100);
  end

  always_comb begin
    src_ok = {1'b0, sel_src} < NP4;
    dst_ok = {1'b0, sel_dst} < NP4;
    src_h  = '0;
    dst_h  = '0;
    for (int i = 0; i < NPILES; i++) begin
      if (sel_src == 3'(i)) src_h = h_p0[i];
      if (sel_dst == 3'(i)) dst_h = h_p0[i];
    end
    src_n  = step_down(src_h);
    dst_n  = step_up(dst_h);
    wr_src = 1'b0;
    wr_dst = 1'b0;
    err_d  = 1'b0;
    tot_d  = total;
    if (issue) begin
      case (v)
        3'b001: begin
          if (!dst_ok || (SAT != 0 && dst_h == HMAX)) err_d = 1'b1;
          else begin
            wr_dst = 1'b1;
            tot_d  = (dst_h == HMAX) ? total - TW'(MAXH) : total + 1'b1;
          end
        end
        3'b010: begin
          if (!src_ok || (SAT != 0 && src_h == '0)) err_d = 1'b1;
          else begin
            wr_src = 1'b1;
            tot_d  = (src_h == '0) ? total + TW'(MAXH) : total - 1'b1;
          end
        end
        3'b100: begin
          // a move never wraps: both ends are range-checked before either pile is touched
          if (!src_ok || !dst_ok || sel_src == sel_dst || src_h == '0 || dst_h == HMAX)
            err_d = 1'b1;
          else begin
            wr_src = 1'b1;
            wr_dst = 1'b1;
          end
        end
        default: ;
      endcase
    end
    for (int i = 0; i < NPILES; i++) begin
      h_d[i] = h_p0[i];
      if (wr_src && sel_src == 3'(i)) h_d[i] = src_n;
      if (wr_dst && sel_dst == 3'(i)) h_d[i] = dst_n;
    end
  end

  // stage p0: filter state, pile heights, total and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      f_p0     <= 3'b000;
      vlast_p0 <= 3'b000;
      cnt_p0   <= '0;
      armed_p0 <= 1'b0;
      error    <= 1'b0;
      total    <= TW'(INIT_H0);
      for (int i = 0; i < NPILES; i++)
        h_p0[i] <= (i == 0) ? WIDTH'(INIT_H0) : '0;
    end else begin
      vlast_p0 <= v;
      if (v == f_p0) cnt_p0 <= '0;
      else if (accept) begin
        f_p0   <= v;
        cnt_p0 <= '0;
      end else cnt_p0 <= run;
      armed_p0 <= armed_p0 | (v == 3'b000);
      error    <= err_d;
      total    <= tot_d;
      h_p0     <= h_d;
    end
  end

  for (genvar g = 0; g < NPILES; g++) begin : g_out
    assign Hauteurs[g*WIDTH +: WIDTH] = h_p0[g];
  end

endmodule

// File: tb/tb_pile_bank.sv
// Scoreboard bench for pile_bank: three configurations share one random stimulus stream,
// each checked every cycle against a button-press-level reference model.
module tb_pile_bank;

  localparam int NP = 3;
  localparam int W  = 3;
  localparam int MH = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       Plus = 1'b0, Moins = 1'b0, Move = 1'b0;
  logic [2:0] sel_src = 3'd0, sel_dst = 3'd0;
  logic [NP*W-1:0] haut [3];
  logic [W+2:0]    tot  [3];
  logic            err  [3];

  pile_bank #(.NPILES(NP), .WIDTH(W), .MAXH(MH), .SAT(1), .DEBOUNCE(0), .INIT_H0(3)) u_a (
    .clk(clk), .reset(reset), .Plus(Plus), .Moins(Moins), .Move(Move),
    .sel_src(sel_src), .sel_dst(sel_dst), .Hauteurs(haut[0]), .total(tot[0]), .error(err[0]));
  pile_bank #(.NPILES(NP), .WIDTH(W), .MAXH(MH), .SAT(0), .DEBOUNCE(0), .INIT_H0(0)) u_b (
    .clk(clk), .reset(reset), .Plus(Plus), .Moins(Moins), .Move(Move),
    .sel_src(sel_src), .sel_dst(sel_dst), .Hauteurs(haut[1]), .total(tot[1]), .error(err[1]));
  pile_bank #(.NPILES(NP), .WIDTH(W), .MAXH(MH), .SAT(1), .DEBOUNCE(2), .INIT_H0(0)) u_c (
    .clk(clk), .reset(reset), .Plus(Plus), .Moins(Moins), .Move(Move),
    .sel_src(sel_src), .sel_dst(sel_dst), .Hauteurs(haut[2]), .total(tot[2]), .error(err[2]));

  int c_sat  [3] = '{1, 0, 1};
  int c_deb  [3] = '{0, 0, 2};
  int c_init [3] = '{3, 0, 0};

  // reference model: heights, accepted button vector, length of current raw run, release-needed flag
  int mh   [3][8];
  int mf   [3];
  int mrun [3];
  int mlv  [3];
  bit mblk [3];

  typedef struct { int k; logic [8:0] h; logic [5:0] t; logic e; } exp_t;
  typedef struct { string nm; logic [8:0] h; logic [5:0] t; logic e; } dir_t;
  exp_t sq[$];
  dir_t dq[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic step(input int k, input bit rst, input int v, input int s, input int d);
    bit e;
    int sum;
    exp_t x;
    e = 1'b0;
    if (rst) begin
      for (int i = 0; i < 8; i++) mh[k][i] = 0;
      mh[k][0] = c_init[k];
      mf[k] = 0; mrun[k] = 0; mlv[k] = 0; mblk[k] = 1'b1;
    end else begin
      mrun[k] = (v == mlv[k] && mrun[k] > 0) ? mrun[k] + 1 : 1;
      mlv[k]  = v;
      if (v == 0) mblk[k] = 1'b0;
      if (v != mf[k] && mrun[k] == c_deb[k] + 1) begin
        if (mf[k] == 0 && !mblk[k]) begin
          if (v == 1) begin
            if (d >= NP || (c_sat[k] == 1 && mh[k][d] == MH)) e = 1'b1;
            else mh[k][d] = (mh[k][d] + 1) % (MH + 1);
          end else if (v == 2) begin
            if (s >= NP || (c_sat[k] == 1 && mh[k][s] == 0)) e = 1'b1;
            else mh[k][s] = (mh[k][s] + MH) % (MH + 1);
          end else if (v == 4) begin
            if (s >= NP || d >= NP || s == d || mh[k][s] == 0 || mh[k][d] == MH) e = 1'b1;
            else begin
              mh[k][s] = mh[k][s] - 1;
              mh[k][d] = mh[k][d] + 1;
            end
          end
        end
        mf[k] = v;
      end
    end
    sum = 0;
    x.h = '0;
    for (int i = 0; i < NP; i++) begin
      x.h[i*W +: W] = 3'(mh[k][i]);
      sum += mh[k][i];
    end
    x.k = k;
    x.t = 6'(sum);
    x.e = e;
    sq.push_back(x);
  endtask

  // drive inputs for the next edge and queue what every instance must show after it
  task automatic cycle(input bit rst, input logic [2:0] v, input logic [2:0] s, input logic [2:0] d);
    @(posedge clk);
    #2;
    reset = rst;
    {Move, Moins, Plus} = v;
    sel_src = s;
    sel_dst = d;
    for (int k = 0; k < 3; k++) step(k, rst, int'(v), int'(s), int'(d));
  endtask

  task automatic expect_a(input string nm, input logic [8:0] h, input logic [5:0] t, input logic e);
    dir_t x;
    x.nm = nm; x.h = h; x.t = t; x.e = e;
    dq.push_back(x);
  endtask

  initial begin
    exp_t x;
    dir_t y;
    forever begin
      @(posedge clk);
      #1;
      while (sq.size() > 0) begin
        x = sq.pop_front();
        vectors++;
        if (haut[x.k] !== x.h || tot[x.k] !== x.t || err[x.k] !== x.e) begin
          miscompares++;
          $display("FAIL inst%0d @%0t: hauteurs=%h total=%0d error=%b, expected hauteurs=%h total=%0d error=%b",
                   x.k, $time, haut[x.k], tot[x.k], err[x.k], x.h, x.t, x.e);
        end
      end
      if (dq.size() > 0) begin
        y = dq.pop_front();
        vectors++;
        if (haut[0] !== y.h || tot[0] !== y.t || err[0] !== y.e) begin
          miscompares++;
          $display("FAIL %s: hauteurs=%h total=%0d error=%b, expected hauteurs=%h total=%0d error=%b",
                   y.nm, haut[0], tot[0], err[0], y.h, y.t, y.e);
        end
      end
    end
  end

  initial begin
    logic [2:0] v, s, d;
    int len;
    bit rst;
    // reset held together with Plus: press must be dropped
    cycle(1'b1, 3'b001, 3'd0, 3'd1);
    cycle(1'b1, 3'b001, 3'd0, 3'd1);
    expect_a("reset_state", 9'h003, 6'd3, 1'b0);
    repeat (3) cycle(1'b0, 3'b001, 3'd0, 3'd1);
    expect_a("held_through_reset", 9'h003, 6'd3, 1'b0);
    cycle(1'b0, 3'b000, 3'd0, 3'd0);
    repeat (10) cycle(1'b0, 3'b001, 3'd0, 3'd1);
    expect_a("plus_held_once", 9'h00B, 6'd4, 1'b0);
    cycle(1'b0, 3'b000, 3'd0, 3'd0);
    repeat (3) begin
      cycle(1'b0, 3'b100, 3'd0, 3'd2);
      cycle(1'b0, 3'b000, 3'd0, 3'd0);
    end
    expect_a("three_moves", 9'h0C8, 6'd4, 1'b0);
    cycle(1'b0, 3'b100, 3'd0, 3'd2);
    expect_a("move_empty_src", 9'h0C8, 6'd4, 1'b1);
    cycle(1'b0, 3'b000, 3'd0, 3'd0);
    expect_a("error_one_cycle", 9'h0C8, 6'd4, 1'b0);
    cycle(1'b0, 3'b001, 3'd0, 3'd3);
    expect_a("plus_bad_index", 9'h0C8, 6'd4, 1'b1);
    cycle(1'b0, 3'b000, 3'd0, 3'd0);
    cycle(1'b0, 3'b100, 3'd1, 3'd1);
    expect_a("move_same_pile", 9'h0C8, 6'd4, 1'b1);
    cycle(1'b0, 3'b000, 3'd0, 3'd0);
    cycle(1'b0, 3'b011, 3'd0, 3'd1);
    expect_a("two_buttons", 9'h0C8, 6'd4, 1'b0);
    cycle(1'b0, 3'b000, 3'd0, 3'd0);

    // short and long pulses for the debounced instance, saturation/wrap on pile 1, Moins at 0
    for (int p = 1; p <= 3; p++) begin
      repeat (p) cycle(1'b0, 3'b001, 3'd0, 3'd0);
      cycle(1'b0, 3'b000, 3'd0, 3'd0);
    end
    repeat (8) begin
      repeat (3) cycle(1'b0, 3'b001, 3'd0, 3'd1);
      cycle(1'b0, 3'b000, 3'd0, 3'd0);
    end
    cycle(1'b1, 3'b000, 3'd0, 3'd0);
    repeat (2) begin
      repeat (3) cycle(1'b0, 3'b010, 3'd0, 3'd0);
      cycle(1'b0, 3'b000, 3'd0, 3'd0);
    end

    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 7))
        0, 1:    v = 3'b001;
        2, 3:    v = 3'b010;
        4, 5:    v = 3'b100;
        6:       v = 3'($urandom_range(3, 7));
        default: v = 3'b000;
      endcase
      len = $urandom_range(1, 5);
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      d = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      for (int c = 0; c < len; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 3) == 0) begin
          s = 3'($urandom_range(0, 3));
          d = 3'($urandom_range(0, 3));
        end
        cycle(rst, v, s, d);
      end
      repeat ($urandom_range(0, 2)) cycle(1'b0, 3'b000, s, d);
    end

    cycle(1'b0, 3'b000, 3'd0, 3'd0);
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
